// File: rtl/decode_5to32_hold.sv
// Sequential 5-to-32 decoder with valid/ready input, programmable hold time and a
// one-entry pending buffer. Define DECODE_THERMO_EN for thermometer output instead of one-hot.
module decode_5to32_hold #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [4:0]  in_code,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        y_valid,
  output logic        done,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_full_q, pend_full_d;
  logic [4:0]  pend_code_q, pend_code_d;
  logic [31:0] y_q, y_d;
  logic        y_valid_q, y_valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        accept_s;

  function automatic logic [31:0] decode_word(input logic [4:0] code);
`ifdef DECODE_THERMO_EN
    logic [32:0] thermo;
    thermo = (33'd2 << code) - 33'd1;
    return thermo[31:0];
`else
    return 32'd1 << code;
`endif
  endfunction

  assign in_ready = en & ~pend_full_q;
  assign accept_s = in_valid & in_ready;

  // Next-state: load, hold countdown, pending hand-over, normal end and abort
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    done_d      = 1'b0;
    if (!en) begin
      state_d     = IDLE;
      cnt_d       = 8'd0;
      pend_full_d = 1'b0;
      y_d         = 32'd0;
      y_valid_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            y_d       = decode_word(in_code);
            y_valid_d = 1'b1;
            cnt_d     = HOLD_LOAD;
            state_d   = HOLD;
          end else begin
            y_d       = 32'd0;
            y_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (accept_s) begin
              pend_full_d = 1'b1;
              pend_code_d = in_code;
            end else begin
              pend_code_d = pend_code_q;
            end
          end else if (pend_full_q) begin
            y_d         = decode_word(pend_code_q);
            cnt_d       = HOLD_LOAD;
            pend_full_d = 1'b0;
          end else if (accept_s) begin
            // last hold cycle with an empty buffer: take the new code straight through
            y_d   = decode_word(in_code);
            cnt_d = HOLD_LOAD;
          end else begin
            y_d       = 32'd0;
            y_valid_d = 1'b0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          pend_full_d = 1'b0;
          y_d         = 32'd0;
          y_valid_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == HOLD) | pend_full_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      pend_full_q <= 1'b0;
      pend_code_q <= 5'd0;
      y_q         <= 32'd0;
      y_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
